// File: rtl/status_flag_unit.sv
// NZCV flag register with an in-flight scoreboard for flag-setting instructions,
// a stale-flag hazard for ID, optional EX->ID bypass and a one-deep exception shadow.
module status_flag_unit #(
    parameter int MAX_INFLIGHT = 2,
    parameter int BYPASS       = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  id_valid,
    input  logic                                  id_s,
    input  logic                                  id_uses_cond,
    input  logic                                  stall_in,
    input  logic                                  flush,
    input  logic                                  ex_valid,
    input  logic                                  ex_s,
    input  logic                                  ex_cond_pass,
    input  logic [3:0]                            ex_nzcv,
    input  logic                                  exc_enter,
    input  logic                                  exc_return,
    output logic [3:0]                            status,
    output logic [3:0]                            cond_flags,
    output logic                                  flags_hazard,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
    output logic [3:0]                            shadow,
    output logic                                  sb_err
);

    localparam int              CW      = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0]   ONE     = CW'(1);

    logic            issue;
    logic            retire;
    logic            write;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            err_set;
    logic [CW-1:0]   pend;
    logic [3:0]      status_commit;
    logic [3:0]      status_nxt;
    logic [3:0]      shadow_nxt;

    assign issue  = id_valid & id_s & ~stall_in & ~flush;
    assign retire = ex_valid & ex_s;
    assign write  = retire & ex_cond_pass;

    always_comb begin
        count_nxt = count;
        err_set   = 1'b0;
        if (flush) begin
            count_nxt = '0;
        end else if (issue && !retire) begin
            if (count == MAX_CNT)
                err_set = 1'b1;
            else
                count_nxt = count + ONE;
        end else if (retire && !issue) begin
            if (count == '0)
                err_set = 1'b1;
            else
                count_nxt = count - ONE;
        end
    end

    // A retiring flag-setter no longer counts as pending when its result is forwarded;
    // the floor at zero keeps an underflowing retire from wrapping into a false hazard.
    always_comb begin
        pend = count;
        if (flush)
            pend = '0;
        else if ((BYPASS != 0) && retire && (count != '0))
            pend = count - ONE;
    end

    assign flags_hazard = id_valid & id_uses_cond & (pend != '0);

    // The EX instruction is older than any flush, so its write still lands.
    always_comb begin
        status_commit = write ? ex_nzcv : status;
        status_nxt    = exc_return ? shadow : status_commit;
        shadow_nxt    = (exc_enter && !exc_return) ? status_commit : shadow;
    end

    assign cond_flags = ((BYPASS != 0) && write && !exc_return) ? ex_nzcv : status;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            sb_err <= 1'b0;
            status <= 4'b0000;
            shadow <= 4'b0000;
        end else begin
            count  <= count_nxt;
            sb_err <= sb_err | err_set;
            status <= status_nxt;
            shadow <= shadow_nxt;
        end
    end

    assign inflight = count;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: linear stimulus steps with hand-computed
// expectations checked by immediate assertions.
module tb_status_flag_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_s;
    logic       id_uses_cond;
    logic       stall_in;
    logic       flush;
    logic       ex_valid;
    logic       ex_s;
    logic       ex_cond_pass;
    logic [3:0] ex_nzcv;
    logic       exc_enter;
    logic       exc_return;
    logic [3:0] status;
    logic [3:0] cond_flags;
    logic       flags_hazard;
    logic [1:0] inflight;
    logic [3:0] shadow;
    logic       sb_err;

    int total;
    int bad;

    status_flag_unit #(.MAX_INFLIGHT(2), .BYPASS(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_s         (id_s),
        .id_uses_cond (id_uses_cond),
        .stall_in     (stall_in),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_s         (ex_s),
        .ex_cond_pass (ex_cond_pass),
        .ex_nzcv      (ex_nzcv),
        .exc_enter    (exc_enter),
        .exc_return   (exc_return),
        .status       (status),
        .cond_flags   (cond_flags),
        .flags_hazard (flags_hazard),
        .inflight     (inflight),
        .shadow       (shadow),
        .sb_err       (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_s = 0; id_uses_cond = 0; stall_in = 0; flush = 0;
        ex_valid = 0; ex_s = 0; ex_cond_pass = 0; ex_nzcv = 4'b0000;
        exc_enter = 0; exc_return = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_write(input logic [3:0] v);
        ex_valid = 1; ex_s = 1; ex_cond_pass = 1; ex_nzcv = v;
    endtask

    task automatic id_issue();
        id_valid = 1; id_s = 1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 0;
        #12;
        chk("rst_status",   status,         4'b0000);
        chk("rst_shadow",   shadow,         4'b0000);
        chk("rst_inflight", {2'b0, inflight}, 4'd0);
        chk("rst_sb_err",   {3'b0, sb_err}, 4'd0);
        rst = 1;
        tick();

        // issue an S instruction
        id_issue();
        #1 chk("issue_no_hazard", {3'b0, flags_hazard}, 4'd0);
        tick();
        chk("issue_inflight", {2'b0, inflight}, 4'd1);

        // conditional in ID, nothing retiring
        idle(); id_valid = 1; id_uses_cond = 1;
        #1 chk("cond_hazard", {3'b0, flags_hazard}, 4'd1);
        tick();
        chk("cond_hold_inflight", {2'b0, inflight}, 4'd1);

        // retire with write 1010, bypass clears the hazard
        ex_write(4'b1010);
        #1;
        chk("bypass_hazard", {3'b0, flags_hazard}, 4'd0);
        chk("bypass_cond",   cond_flags, 4'b1010);
        chk("pre_status",    status,     4'b0000);
        tick();
        chk("write_status",   status,   4'b1010);
        chk("write_inflight", {2'b0, inflight}, 4'd0);

        // issue + write same cycle, status -> 0100
        idle(); id_issue(); ex_write(4'b0100);
        tick();
        chk("iw_status",   status, 4'b0100);
        chk("iw_inflight", {2'b0, inflight}, 4'd0);
        idle(); id_issue();
        tick();
        chk("issue2_inflight", {2'b0, inflight}, 4'd1);

        // retire failing condition
        idle(); ex_valid = 1; ex_s = 1; ex_cond_pass = 0; ex_nzcv = 4'b1111;
        #1 chk("nopass_cond", cond_flags, 4'b0100);
        tick();
        chk("nopass_status",   status, 4'b0100);
        chk("nopass_inflight", {2'b0, inflight}, 4'd0);

        // exception shadow
        idle(); id_issue(); ex_write(4'b0011);
        tick();
        chk("pre_exc_status", status, 4'b0011);
        idle(); id_issue(); ex_write(4'b1000); exc_enter = 1;
        tick();
        chk("enter_shadow", shadow, 4'b1000);
        chk("enter_status", status, 4'b1000);
        idle(); id_issue(); ex_write(4'b0110);
        tick();
        chk("later_status", status, 4'b0110);
        chk("later_shadow", shadow, 4'b1000);
        idle(); id_issue(); ex_write(4'b1111); exc_return = 1;
        #1 chk("return_cond", cond_flags, 4'b0110);
        tick();
        chk("return_status", status, 4'b1000);
        chk("return_shadow", shadow, 4'b1000);
        chk("return_inflight", {2'b0, inflight}, 4'd0);

        // fill scoreboard, stall blocks issue
        idle(); id_issue();
        tick();
        tick();
        chk("fill_inflight", {2'b0, inflight}, 4'd2);
        stall_in = 1;
        tick();
        chk("stall_inflight", {2'b0, inflight}, 4'd2);
        chk("stall_sb_err",   {3'b0, sb_err}, 4'd0);

        // flush with a write: hazard present without flush, gone with it
        idle(); id_valid = 1; id_uses_cond = 1; ex_write(4'b0001);
        #1 chk("pend1_hazard", {3'b0, flags_hazard}, 4'd1);
        flush = 1;
        #1 chk("flush_hazard", {3'b0, flags_hazard}, 4'd0);
        tick();
        chk("flush_status",   status, 4'b0001);
        chk("flush_inflight", {2'b0, inflight}, 4'd0);
        chk("flush_sb_err",   {3'b0, sb_err}, 4'd0);

        // overflow
        idle(); id_issue();
        tick();
        tick();
        tick();
        chk("ovf_inflight", {2'b0, inflight}, 4'd2);
        chk("ovf_sb_err",   {3'b0, sb_err}, 4'd1);

        // mid-operation reset, then underflow
        idle();
        #2 rst = 0;
        #1;
        chk("mid_rst_inflight", {2'b0, inflight}, 4'd0);
        chk("mid_rst_sb_err",   {3'b0, sb_err}, 4'd0);
        chk("mid_rst_status",   status, 4'b0000);
        rst = 1;
        tick();
        ex_valid = 1; ex_s = 1; ex_cond_pass = 0;
        tick();
        chk("unf_sb_err",   {3'b0, sb_err}, 4'd1);
        chk("unf_inflight", {2'b0, inflight}, 4'd0);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Holds the architectural NZCV flags and delivers them as the `cond` input of the condition-check stage in ID. It commits flag updates from flag-setting (S-bit) instructions retiring from EX and scoreboards those instructions while they are in flight. It raises a hazard when an ID-stage conditional instruction would read stale flags, with optional same-cycle bypass from EX. It also keeps a one-deep shadow copy of the flags for exception entry and return.

## Interface
Parameters:
- MAX_INFLIGHT, 2: maximum number of flag-setting instructions between ID issue and EX retire.
- BYPASS, 1: when 1, flags retiring in EX are forwarded combinationally to cond_flags.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_s  input  1  ID instruction sets flags.
- id_uses_cond  input  1  ID instruction condition is not AL.
- stall_in  input  1  pipeline freeze; ID does not issue.
- flush  input  1  kill all in-flight instructions younger than EX.
- ex_valid  input  1  EX holds a valid instruction retiring this cycle.
- ex_s  input  1  the EX instruction was issued as flag-setting.
- ex_cond_pass  input  1  the EX instruction passed its condition check.
- ex_nzcv  input  4  new flags from the ALU, as {N,Z,C,V}.
- exc_enter  input  1  copy the flags to the shadow register.
- exc_return  input  1  restore the flags from the shadow register.
- status  output  4  committed NZCV register.
- cond_flags  output  4  NZCV presented to condition check.
- flags_hazard  output  1  ID must stall.
- inflight  output  $clog2(MAX_INFLIGHT+1)  scoreboard count.
- shadow  output  4  saved NZCV.
- sb_err  output  1  sticky scoreboard overflow or underflow.

## Operation
- Events:
  - issue = id_valid & id_s & ~stall_in & ~flush.
  - retire = ex_valid & ex_s.
  - write = retire & ex_cond_pass.
- Scoreboard next value:
  - flush: count goes to 0, even if issue or retire is active.
  - otherwise: count + issue − retire.
  - Saturates at MAX_INFLIGHT. An issue at MAX_INFLIGHT with no retire holds the count and sets sb_err.
  - A retire at 0 with no issue holds 0 and sets sb_err.
  - sb_err clears only on reset.
- Status next value, in priority order:
  1. exc_return: status ← shadow.
  2. write: status ← ex_nzcv.
  3. otherwise: hold.
- A retire with ex_cond_pass=0 leaves status unchanged and still decrements the count.
- Shadow:
  - exc_enter & ~exc_return: shadow ← the status value being committed this cycle, i.e. ex_nzcv if write, else status.
  - Simultaneous exc_enter and exc_return: return wins and shadow holds.
- flush does not block a same-cycle write or exc_return; the instruction in EX is older than the flush.
- Effective pending count:
  - pend = count − (BYPASS & retire).
  - With flush active, pend = 0.
- cond_flags:
  - BYPASS=1 and write and ~exc_return: ex_nzcv.
  - otherwise: status.
- flags_hazard = id_valid & id_uses_cond & (pend != 0).
- An unconditional (AL) instruction never hazards. An S instruction issuing does not hazard on itself.

## Timing
- Reset, asynchronous on rst low: status=0000, shadow=0000, inflight=0, sb_err=0.
- All registers update on the rising edge of clk.
- flags_hazard and cond_flags are combinational from the current inputs and registers. Zero-cycle bypass when BYPASS=1; with BYPASS=0 the new flags appear one cycle after write.
- Back-to-back sequence with BYPASS=1: an S instruction issued at cycle t and retiring at t+1 lets a conditional instruction in ID at t+1 proceed without a stall.
- Reset asserted mid-operation drops all in-flight state immediately. Retires arriving after reset release count as underflow; the pipeline is expected to be reset at the same time.
- stall_in freezes issue only. Retire and write are still honoured during a stall.

## Test plan
- Reset, then ex write with ex_nzcv=1010 → status=1010 next cycle; with BYPASS=1, cond_flags=1010 in the same cycle.
- Issue an S instruction (inflight→1), then a conditional instruction in ID with no retire → flags_hazard=1. Retire with write the next cycle → flags_hazard=0 (BYPASS=1), inflight→0.
- Retire with ex_cond_pass=0, ex_nzcv=1111 while status=0100 → status stays 0100, inflight decrements.
- Two issues, then a third issue with no retire (MAX_INFLIGHT=2) → inflight holds 2 and sb_err=1. After reset, a retire at 0 → sb_err=1 and inflight stays 0.
- status=0011, exc_enter with a same-cycle write of 1000 → shadow=1000. Later write 0110, then exc_return together with a write of 1111 → status=1000.
- inflight=2, flush together with a write of 0001 → status=0001, inflight=0, flags_hazard=0 in the flush cycle.
